// File: rtl/tdm_pkg.sv
// Shared definitions for the two-slot TDM mux/demux pair.
package tdm_pkg;

  localparam logic SLOT_A = 1'b0;
  localparam logic SLOT_B = 1'b1;

  localparam int DEFAULT_WIDTH = 8;

endpackage

// File: rtl/demux_out_stage.sv
// One-entry registered output stage with a valid/ready handshake.
module demux_out_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  input  logic             ready
);

  // A load wins over a consume, so a same-cycle load/consume keeps valid high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      dout  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      dout  <= din;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/tdm_demux2.sv
// Two-slot TDM demultiplexer: splits an A/B interleaved stream into two
// handshaked channels, tracking frame alignment and completed frames.
module tdm_demux2
  import tdm_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
  input  logic             s_sync,
  output logic             s_ready,
  output logic [WIDTH-1:0] a_data,
  output logic             a_valid,
  input  logic             a_ready,
  output logic [WIDTH-1:0] b_data,
  output logic             b_valid,
  input  logic             b_ready,
  output logic             sync_err,
  output logic [CNT_W-1:0] frame_cnt
);

  logic slot;
  logic target_a;
  logic accept;
  logic load_a;
  logic load_b;

  // A sync beat always restarts the frame on A, regardless of the pointer.
  assign target_a = s_sync | (slot == SLOT_A);
  assign s_ready  = target_a ? (~a_valid | a_ready) : (~b_valid | b_ready);
  assign accept   = s_valid & s_ready;
  assign load_a   = accept & target_a;
  assign load_b   = accept & ~target_a;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot <= SLOT_A;
    end else if (accept) begin
      slot <= load_a ? SLOT_B : SLOT_A;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_err <= 1'b0;
    end else if (load_a && s_sync && (slot == SLOT_B)) begin
      sync_err <= 1'b1;
    end
  end

  // Only a completed B slot closes a frame; an abandoned B slot is not counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt <= '0;
    end else if (load_b) begin
      frame_cnt <= frame_cnt + CNT_W'(1);
    end
  end

  demux_out_stage #(.WIDTH(WIDTH)) u_stage_a (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load_a),
    .din   (s_data),
    .dout  (a_data),
    .valid (a_valid),
    .ready (a_ready)
  );

  demux_out_stage #(.WIDTH(WIDTH)) u_stage_b (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (load_b),
    .din   (s_data),
    .dout  (b_data),
    .valid (b_valid),
    .ready (b_ready)
  );

endmodule
